// File: rtl/hazard_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control_unit_if
//  Description : ID-stage instruction/operand/hazard inputs and the ID/EX
//                control, fetch-redirect and status outputs of the decode unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_control_unit_if #(
    parameter int WORD  = 32,
    parameter int CNT_W = 16
);
    logic [31:0]      instr_d;
    logic [WORD-1:0]  reg_rs_d;
    logic [WORD-1:0]  reg_rt_d;
    logic             ex_mem_r;
    logic             ex_wb_en;
    logic [4:0]       ex_rd;
    logic             mem_mem_r;
    logic [4:0]       mem_rd;

    logic             is_immd;
    logic             mem_w;
    logic             mem_r;
    logic             wb_en;
    logic             only_shamt;
    logic             is_branch;
    logic [3:0]       alu_op;
    logic             stall;
    logic             branch_taken;
    logic             jump_taken;
    logic             flush_f;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output instr_d, reg_rs_d, reg_rt_d, ex_mem_r, ex_wb_en, ex_rd, mem_mem_r, mem_rd,
        input  is_immd, mem_w, mem_r, wb_en, only_shamt, is_branch, alu_op,
        input  stall, branch_taken, jump_taken, flush_f, halted, stall_cnt
    );

    modport slave (
        input  instr_d, reg_rs_d, reg_rt_d, ex_mem_r, ex_wb_en, ex_rd, mem_mem_r, mem_rd,
        output is_immd, mem_w, mem_r, wb_en, only_shamt, is_branch, alu_op,
        output stall, branch_taken, jump_taken, flush_f, halted, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control_unit
//  Description : MIPS decode-stage control with load-use/branch stalls, fetch
//                squash on taken branches/jumps and a drain-then-halt FSM.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_control_unit #(
    parameter int WORD         = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input logic                  clk,
    input logic                  rst,
    hazard_control_unit_if.slave bus
);

    localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [5:0] c_op_rtype = 6'h00, c_op_j    = 6'h02, c_op_jal  = 6'h03,
                           c_op_beq   = 6'h04, c_op_bne  = 6'h05, c_op_addi = 6'h08,
                           c_op_addiu = 6'h09, c_op_andi = 6'h0C, c_op_ori  = 6'h0D,
                           c_op_xori  = 6'h0E, c_op_lw   = 6'h23, c_op_sw   = 6'h2B;

    localparam logic [5:0] c_fn_sll  = 6'h00, c_fn_srl  = 6'h02, c_fn_sra  = 6'h03,
                           c_fn_sllv = 6'h04, c_fn_srlv = 6'h06, c_fn_srav = 6'h07,
                           c_fn_jr   = 6'h08, c_fn_jalr = 6'h09, c_fn_add  = 6'h20,
                           c_fn_addu = 6'h21, c_fn_sub  = 6'h22, c_fn_subu = 6'h23,
                           c_fn_and  = 6'h24, c_fn_or   = 6'h25, c_fn_xor  = 6'h26,
                           c_fn_nor  = 6'h27, c_fn_slt  = 6'h2A;

    localparam logic [3:0] c_alu_nop = 4'd0,  c_alu_add = 4'd1,  c_alu_addu = 4'd2,
                           c_alu_sub = 4'd3,  c_alu_subu = 4'd4, c_alu_and  = 4'd5,
                           c_alu_or  = 4'd6,  c_alu_xor = 4'd7,  c_alu_nor  = 4'd8,
                           c_alu_le  = 4'd9,  c_alu_shl = 4'd10, c_alu_shr  = 4'd11,
                           c_alu_shra = 4'd12;

    typedef struct packed {
        logic       is_immd;
        logic       mem_w;
        logic       mem_r;
        logic       wb_en;
        logic       only_shamt;
        logic       is_branch;
        logic [3:0] alu_op;
    } ctrl_t;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DC_W-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    ctrl_t             ctrl_q, ctrl_d;

    ctrl_t             w_dec;
    logic              w_uses_rs, w_uses_rt, w_is_cond_br, w_is_bne, w_is_jump, w_chk_br_hz;
    logic              w_is_term, w_ex_match, w_mem_match, w_hazard, w_operands_eq;
    logic              w_stall, w_branch, w_jump, w_issue;
    logic [5:0]        w_op, w_fn;
    logic [4:0]        w_rs, w_rt;

    assign w_op      = bus.instr_d[31:26];
    assign w_fn      = bus.instr_d[5:0];
    assign w_rs      = bus.instr_d[25:21];
    assign w_rt      = bus.instr_d[20:16];
    assign w_is_term = (bus.instr_d == 32'hFFFF_FFFF);

    always_comb begin
        w_dec        = '0;
        w_uses_rs    = 1'b0;
        w_uses_rt    = 1'b0;
        w_is_cond_br = 1'b0;
        w_is_bne     = 1'b0;
        w_is_jump    = 1'b0;
        w_chk_br_hz  = 1'b0;
        case (w_op)
            c_op_rtype: begin
                w_uses_rs   = 1'b1;
                w_uses_rt   = 1'b1;
                w_dec.wb_en = 1'b1;
                case (w_fn)
                    c_fn_add:  w_dec.alu_op = c_alu_add;
                    c_fn_addu: w_dec.alu_op = c_alu_addu;
                    c_fn_sub:  w_dec.alu_op = c_alu_sub;
                    c_fn_subu: w_dec.alu_op = c_alu_subu;
                    c_fn_and:  w_dec.alu_op = c_alu_and;
                    c_fn_or:   w_dec.alu_op = c_alu_or;
                    c_fn_xor:  w_dec.alu_op = c_alu_xor;
                    c_fn_nor:  w_dec.alu_op = c_alu_nor;
                    c_fn_slt:  w_dec.alu_op = c_alu_le;
                    c_fn_sllv: w_dec.alu_op = c_alu_shl;
                    c_fn_srlv: w_dec.alu_op = c_alu_shr;
                    c_fn_srav: w_dec.alu_op = c_alu_shra;
                    c_fn_sll, c_fn_srl, c_fn_sra: begin
                        // Immediate shifts take the shamt field, so rs is not a source.
                        w_uses_rs        = 1'b0;
                        w_dec.only_shamt = 1'b1;
                        w_dec.alu_op     = (w_fn == c_fn_sll) ? c_alu_shl :
                                           (w_fn == c_fn_srl) ? c_alu_shr : c_alu_shra;
                    end
                    c_fn_jr, c_fn_jalr: begin
                        w_dec.wb_en = 1'b0;
                        w_is_jump   = 1'b1;
                        w_chk_br_hz = 1'b1;
                    end
                    default: begin
                        w_uses_rs   = 1'b0;
                        w_uses_rt   = 1'b0;
                        w_dec.wb_en = 1'b0;
                    end
                endcase
            end
            c_op_j, c_op_jal: w_is_jump = 1'b1;
            c_op_beq, c_op_bne: begin
                w_uses_rs       = 1'b1;
                w_uses_rt       = 1'b1;
                w_is_cond_br    = 1'b1;
                w_is_bne        = (w_op == c_op_bne);
                w_chk_br_hz     = 1'b1;
                w_dec.is_branch = 1'b1;
                w_dec.alu_op    = c_alu_nop;
            end
            c_op_addi, c_op_addiu, c_op_andi, c_op_ori, c_op_xori: begin
                w_uses_rs     = 1'b1;
                w_dec.is_immd = 1'b1;
                w_dec.wb_en   = 1'b1;
                w_dec.alu_op  = (w_op == c_op_andi) ? c_alu_and :
                                (w_op == c_op_ori)  ? c_alu_or  :
                                (w_op == c_op_xori) ? c_alu_xor : c_alu_add;
            end
            c_op_lw: begin
                w_uses_rs     = 1'b1;
                w_dec.is_immd = 1'b1;
                w_dec.mem_r   = 1'b1;
                w_dec.wb_en   = 1'b1;
                w_dec.alu_op  = c_alu_add;
            end
            c_op_sw: begin
                w_uses_rs     = 1'b1;
                w_uses_rt     = 1'b1;
                w_dec.is_immd = 1'b1;
                w_dec.mem_w   = 1'b1;
                w_dec.alu_op  = c_alu_add;
            end
            default: ;
        endcase
    end

    // $0 is hard-wired, so a producer targeting it never creates a dependency.
    assign w_ex_match  = (bus.ex_rd != 5'd0) &&
                         ((w_uses_rs && bus.ex_rd == w_rs) || (w_uses_rt && bus.ex_rd == w_rt));
    assign w_mem_match = (bus.mem_rd != 5'd0) &&
                         ((w_uses_rs && bus.mem_rd == w_rs) || (w_uses_rt && bus.mem_rd == w_rt));
    assign w_hazard    = (bus.ex_mem_r && w_ex_match) ||
                         (w_chk_br_hz && ((bus.ex_wb_en && w_ex_match) ||
                                          (bus.mem_mem_r && w_mem_match)));
    assign w_operands_eq = (bus.reg_rs_d == bus.reg_rt_d);

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        w_stall  = 1'b0;
        w_branch = 1'b0;
        w_jump   = 1'b0;
        w_issue  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (w_hazard) begin
                    w_stall = 1'b1;
                end else if (w_is_term) begin
                    w_stall = 1'b1;
                    state_d = S_DRAIN;
                    drain_d = DC_W'(DRAIN_CYCLES);
                end else begin
                    w_issue  = 1'b1;
                    w_branch = w_is_cond_br && (w_operands_eq != w_is_bne);
                    w_jump   = w_is_jump;
                end
            end
            S_DRAIN: begin
                w_stall = 1'b1;
                drain_d = drain_q - DC_W'(1);
                if (drain_q <= DC_W'(1)) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: w_stall = 1'b1;
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        ctrl_d      = w_issue ? w_dec : '0;
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_RUN && w_stall && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            ctrl_q      <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign bus.is_immd      = ctrl_q.is_immd;
    assign bus.mem_w        = ctrl_q.mem_w;
    assign bus.mem_r        = ctrl_q.mem_r;
    assign bus.wb_en        = ctrl_q.wb_en;
    assign bus.only_shamt   = ctrl_q.only_shamt;
    assign bus.is_branch    = ctrl_q.is_branch;
    assign bus.alu_op       = ctrl_q.alu_op;
    assign bus.halted       = (state_q == S_HALT);
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.stall        = w_stall  && !rst;
    assign bus.branch_taken = w_branch && !rst;
    assign bus.jump_taken   = w_jump   && !rst;
    assign bus.flush_f      = (w_branch || w_jump) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_control_unit
//  Description : Self-checking bench: directed vector table, hand sequences and
//                random stimulus against a behavioural pipeline-control model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_control_unit;

    localparam int DRAIN = 4;

    localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                           OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                           OP_LW = 6'h23, OP_SW = 6'h2B, OP_JAL = 6'h03;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                           F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09,
                           F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                           F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                           F_SLT = 6'h2A;
    localparam logic [3:0] A_NOP = 4'd0, A_ADD = 4'd1, A_ADDU = 4'd2, A_SUB = 4'd3,
                           A_SUBU = 4'd4, A_AND = 4'd5, A_OR = 4'd6, A_XOR = 4'd7,
                           A_NOR = 4'd8, A_LE = 4'd9, A_SHL = 4'd10, A_SHR = 4'd11,
                           A_SHRA = 4'd12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.WORD(32), .CNT_W(16)) b1 ();
    hazard_control_unit_if #(.WORD(32), .CNT_W(3))  b2 ();

    hazard_control_unit #(.WORD(32), .DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(b1));
    hazard_control_unit #(.WORD(32), .DRAIN_CYCLES(DRAIN), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .bus(b2));

    assign b2.instr_d   = b1.instr_d;
    assign b2.reg_rs_d  = b1.reg_rs_d;
    assign b2.reg_rt_d  = b1.reg_rt_d;
    assign b2.ex_mem_r  = b1.ex_mem_r;
    assign b2.ex_wb_en  = b1.ex_wb_en;
    assign b2.ex_rd     = b1.ex_rd;
    assign b2.mem_mem_r = b1.mem_mem_r;
    assign b2.mem_rd    = b1.mem_rd;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rinst(input logic [5:0] fn, input int s, input int t,
                                          input int d, input int sh);
        logic [4:0] s5 = s[4:0], t5 = t[4:0], d5 = d[4:0], h5 = sh[4:0];
        return {6'h00, s5, t5, d5, h5, fn};
    endfunction

    function automatic logic [31:0] iinst(input logic [5:0] op, input int s, input int t,
                                          input logic [15:0] imm);
        logic [4:0] s5 = s[4:0], t5 = t[4:0];
        return {op, s5, t5, imm};
    endfunction

    function automatic logic [9:0] mk(input bit immd, input bit mw, input bit mr, input bit wb,
                                      input bit sh, input bit br, input logic [3:0] alu);
        return {immd, mw, mr, wb, sh, br, alu};
    endfunction

    // ---------------- behavioural reference ----------------
    typedef struct packed {
        logic [9:0] ctrl;
        bit use_s, use_t, cond_br, bne, jmp, brchk, term;
    } ref_t;

    function automatic ref_t ref_dec(input logic [31:0] ins);
        ref_t r = '0;
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        bit known = 1'b1;
        if (ins == 32'hFFFF_FFFF) begin
            r.term = 1'b1;
            return r;
        end
        if (op == 6'h00) begin
            case (fn)
                F_ADD:  r.ctrl = mk(0,0,0,1,0,0,A_ADD);
                F_ADDU: r.ctrl = mk(0,0,0,1,0,0,A_ADDU);
                F_SUB:  r.ctrl = mk(0,0,0,1,0,0,A_SUB);
                F_SUBU: r.ctrl = mk(0,0,0,1,0,0,A_SUBU);
                F_AND:  r.ctrl = mk(0,0,0,1,0,0,A_AND);
                F_OR:   r.ctrl = mk(0,0,0,1,0,0,A_OR);
                F_XOR:  r.ctrl = mk(0,0,0,1,0,0,A_XOR);
                F_NOR:  r.ctrl = mk(0,0,0,1,0,0,A_NOR);
                F_SLT:  r.ctrl = mk(0,0,0,1,0,0,A_LE);
                F_SLLV: r.ctrl = mk(0,0,0,1,0,0,A_SHL);
                F_SRLV: r.ctrl = mk(0,0,0,1,0,0,A_SHR);
                F_SRAV: r.ctrl = mk(0,0,0,1,0,0,A_SHRA);
                F_SLL:  r.ctrl = mk(0,0,0,1,1,0,A_SHL);
                F_SRL:  r.ctrl = mk(0,0,0,1,1,0,A_SHR);
                F_SRA:  r.ctrl = mk(0,0,0,1,1,0,A_SHRA);
                F_JR, F_JALR: begin r.jmp = 1'b1; r.brchk = 1'b1; end
                default: known = 1'b0;
            endcase
            r.use_t = known;
            r.use_s = known && !(fn == F_SLL || fn == F_SRL || fn == F_SRA);
        end else begin
            case (op)
                OP_J, OP_JAL:      r.jmp = 1'b1;
                OP_BEQ, OP_BNE: begin
                    r.ctrl = mk(0,0,0,0,0,1,A_NOP);
                    r.cond_br = 1'b1; r.bne = (op == OP_BNE); r.brchk = 1'b1;
                    r.use_s = 1'b1; r.use_t = 1'b1;
                end
                OP_ADDI, OP_ADDIU: begin r.ctrl = mk(1,0,0,1,0,0,A_ADD); r.use_s = 1'b1; end
                OP_ANDI: begin r.ctrl = mk(1,0,0,1,0,0,A_AND); r.use_s = 1'b1; end
                OP_ORI:  begin r.ctrl = mk(1,0,0,1,0,0,A_OR);  r.use_s = 1'b1; end
                OP_XORI: begin r.ctrl = mk(1,0,0,1,0,0,A_XOR); r.use_s = 1'b1; end
                OP_LW:   begin r.ctrl = mk(1,0,1,1,0,0,A_ADD); r.use_s = 1'b1; end
                OP_SW:   begin r.ctrl = mk(1,1,0,0,0,0,A_ADD); r.use_s = 1'b1; r.use_t = 1'b1; end
                default: ;
            endcase
        end
        return r;
    endfunction

    function automatic bit reads(input ref_t d, input logic [31:0] ins, input logic [4:0] rd);
        return (rd != 5'd0) && ((d.use_s && ins[25:21] == rd) || (d.use_t && ins[20:16] == rd));
    endfunction

    int         m_left   = 0;     // drain bubbles still to issue
    bit         m_halted = 1'b0;
    int         m_cnt1   = 0;
    int         m_cnt2   = 0;
    logic [9:0] m_ctrl   = '0;
    logic       s_stall, s_bt, s_jt;

    task automatic cycle(input bit r);
        ref_t d;
        bit   hz, run, stl, e_bt, e_jt;
        rst = r;
        @(negedge clk);
        d   = ref_dec(b1.instr_d);
        hz  = (b1.ex_mem_r && reads(d, b1.instr_d, b1.ex_rd)) ||
              (d.brchk && ((b1.ex_wb_en && reads(d, b1.instr_d, b1.ex_rd)) ||
                           (b1.mem_mem_r && reads(d, b1.instr_d, b1.mem_rd))));
        run  = !m_halted && m_left == 0;
        stl  = !run || hz || d.term;
        e_bt = !r && !stl && d.cond_br && ((b1.reg_rs_d == b1.reg_rt_d) != d.bne);
        e_jt = !r && !stl && d.jmp;
        s_stall = b1.stall; s_bt = b1.branch_taken; s_jt = b1.jump_taken;
        chk("stall", b1.stall, !r && stl);
        chk("branch_taken", b1.branch_taken, e_bt);
        chk("jump_taken", b1.jump_taken, e_jt);
        chk("flush_f", b1.flush_f, e_bt || e_jt);
        @(posedge clk);
        #1;
        if (r) begin
            m_left = 0; m_halted = 1'b0; m_cnt1 = 0; m_cnt2 = 0; m_ctrl = '0;
        end else begin
            if (run && stl) begin
                m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : m_cnt1;
                m_cnt2 = (m_cnt2 < 7) ? m_cnt2 + 1 : m_cnt2;
            end
            m_ctrl = stl ? 10'd0 : d.ctrl;
            if (m_halted) begin
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_halted = 1'b1;
            end else if (!hz && d.term) begin
                m_left = DRAIN;
            end
        end
        chk("idex_ctrl", {b1.is_immd, b1.mem_w, b1.mem_r, b1.wb_en, b1.only_shamt,
                          b1.is_branch, b1.alu_op}, m_ctrl);
        chk("halted", b1.halted, m_halted);
        chk("stall_cnt", b1.stall_cnt, m_cnt1);
        chk("stall_cnt_w3", b2.stall_cnt, m_cnt2);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] rsv, input logic [31:0] rtv,
                         input bit exm, input bit exw, input int exrd, input bit mmr, input int mrd);
        b1.instr_d = ins; b1.reg_rs_d = rsv; b1.reg_rt_d = rtv;
        b1.ex_mem_r = exm; b1.ex_wb_en = exw; b1.ex_rd = exrd[4:0];
        b1.mem_mem_r = mmr; b1.mem_rd = mrd[4:0];
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] ins, rsv, rtv;
        bit          exm, exw;
        int          exrd;
        bit          mmr;
        int          mrd;
        logic [9:0]  ctrl;
        bit          stl, bt, jt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [31:0] ins, input logic [31:0] rsv, input logic [31:0] rtv,
                               input bit exm, input bit exw, input int exrd, input bit mmr,
                               input int mrd, input logic [9:0] ctrl, input bit stl,
                               input bit bt, input bit jt);
        vec_t x;
        x.ins = ins; x.rsv = rsv; x.rtv = rtv; x.exm = exm; x.exw = exw; x.exrd = exrd;
        x.mmr = mmr; x.mrd = mrd; x.ctrl = ctrl; x.stl = stl; x.bt = bt; x.jt = jt;
        return x;
    endfunction

    logic [5:0] rnd_ops [12] = '{6'h00, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
                                 OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW};
    logic [5:0] rnd_fns [19] = '{F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_JR, F_JALR,
                                 F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                                 F_SLT, 6'h3F, 6'h01};

    initial begin
        logic [31:0] add324;
        add324 = rinst(F_ADD, 2, 4, 3, 0);
        drive(32'hFFFF_FFFF, 0, 0, 1, 1, 2, 1, 2);
        cycle(1);
        chk("rst_stall_zero", s_stall, 0);
        cycle(1);
        chk("rst_halted", b1.halted, 0);
        chk("rst_cnt", b1.stall_cnt, 0);
        chk("rst_wb_en", b1.wb_en, 0);

        vecs.push_back(v(add324, 0, 0, 0,0,0, 0,0, mk(0,0,0,1,0,0,A_ADD), 0,0,0));
        vecs.push_back(v(iinst(OP_LW, 1, 5, 16'h10), 0,0, 0,0,0, 0,0, mk(1,0,1,1,0,0,A_ADD), 0,0,0));
        vecs.push_back(v(iinst(OP_SW, 1, 5, 16'h4), 0,0, 0,0,0, 0,0, mk(1,1,0,0,0,0,A_ADD), 0,0,0));
        vecs.push_back(v(iinst(OP_ORI, 1, 5, 16'h4), 0,0, 0,0,0, 0,0, mk(1,0,0,1,0,0,A_OR), 0,0,0));
        vecs.push_back(v(iinst(OP_XORI, 1, 5, 16'h4), 0,0, 0,0,0, 0,0, mk(1,0,0,1,0,0,A_XOR), 0,0,0));
        vecs.push_back(v(rinst(F_SRA, 0, 2, 1, 3), 0,0, 0,0,0, 0,0, mk(0,0,0,1,1,0,A_SHRA), 0,0,0));
        vecs.push_back(v(rinst(F_SLLV, 3, 2, 1, 0), 0,0, 0,0,0, 0,0, mk(0,0,0,1,0,0,A_SHL), 0,0,0));
        vecs.push_back(v(rinst(F_SLT, 3, 2, 1, 0), 0,0, 0,0,0, 0,0, mk(0,0,0,1,0,0,A_LE), 0,0,0));
        vecs.push_back(v(rinst(F_SUBU, 3, 2, 1, 0), 0,0, 0,0,0, 0,0, mk(0,0,0,1,0,0,A_SUBU), 0,0,0));
        vecs.push_back(v(iinst(OP_BNE, 1, 2, 16'h8), 1,1, 0,0,0, 0,0, mk(0,0,0,0,0,1,A_NOP), 0,0,0));
        vecs.push_back(v(iinst(OP_BNE, 1, 2, 16'h8), 1,32'h8000_0001, 0,0,0, 0,0, mk(0,0,0,0,0,1,A_NOP), 0,1,0));
        vecs.push_back(v(iinst(OP_BEQ, 1, 2, 16'h8), 7,7, 0,0,0, 0,0, mk(0,0,0,0,0,1,A_NOP), 0,1,0));
        vecs.push_back(v(iinst(OP_J, 0, 0, 16'h40), 0,0, 0,0,0, 0,0, 10'd0, 0,0,1));
        vecs.push_back(v(rinst(F_JR, 31, 0, 0, 0), 0,0, 0,0,0, 0,0, 10'd0, 0,0,1));
        vecs.push_back(v(add324, 0,0, 1,0,2, 0,0, 10'd0, 1,0,0));
        vecs.push_back(v(rinst(F_ADD, 0, 4, 3, 0), 0,0, 1,0,0, 0,0, mk(0,0,0,1,0,0,A_ADD), 0,0,0));
        vecs.push_back(v(iinst(OP_BEQ, 5, 0, 16'h8), 7,7, 0,1,5, 0,0, 10'd0, 1,0,0));
        vecs.push_back(v(iinst(OP_BNE, 1, 6, 16'h8), 1,2, 0,0,0, 1,6, 10'd0, 1,0,0));
        vecs.push_back(v(rinst(F_ADD, 6, 4, 3, 0), 0,0, 0,0,0, 1,6, mk(0,0,0,1,0,0,A_ADD), 0,0,0));
        vecs.push_back(v(rinst(F_ADD, 3, 3, 4, 0), 0,0, 0,1,3, 0,0, mk(0,0,0,1,0,0,A_ADD), 0,0,0));
        vecs.push_back(v(iinst(6'h3E, 1, 2, 16'h0), 0,0, 1,1,2, 1,1, 10'd0, 0,0,0));
        vecs.push_back(v(rinst(F_SLL, 5, 2, 1, 4), 0,0, 1,0,5, 0,0, mk(0,0,0,1,1,0,A_SHL), 0,0,0));
        vecs.push_back(v(rinst(F_JALR, 4, 0, 31, 0), 0,0, 0,0,0, 1,4, 10'd0, 1,0,0));
        vecs.push_back(v(iinst(OP_SW, 1, 5, 16'h4), 0,0, 1,0,5, 0,0, 10'd0, 1,0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].ins, vecs[i].rsv, vecs[i].rtv, vecs[i].exm, vecs[i].exw,
                  vecs[i].exrd, vecs[i].mmr, vecs[i].mrd);
            cycle(0);
            chk($sformatf("vec%0d_stall", i), s_stall, vecs[i].stl);
            chk($sformatf("vec%0d_bt", i), s_bt, vecs[i].bt);
            chk($sformatf("vec%0d_jt", i), s_jt, vecs[i].jt);
            chk($sformatf("vec%0d_ctrl", i), {b1.is_immd, b1.mem_w, b1.mem_r, b1.wb_en,
                b1.only_shamt, b1.is_branch, b1.alu_op}, vecs[i].ctrl);
        end

        // load-use: one stall cycle, then the ADD issues
        drive(add324, 0, 0, 1, 1, 2, 0, 0);
        cycle(0);
        chk("lu_stall", s_stall, 1);
        chk("lu_bubble", b1.wb_en, 0);
        drive(add324, 0, 0, 0, 0, 0, 0, 0);
        cycle(0);
        chk("lu_resume_stall", s_stall, 0);
        chk("lu_resume_alu", b1.alu_op, A_ADD);

        // branch operand hazard, then resolution
        drive(iinst(OP_BEQ, 5, 0, 16'h8), 7, 7, 0, 1, 5, 0, 0);
        cycle(0);
        chk("bh_stall", s_stall, 1);
        chk("bh_bt", s_bt, 0);
        drive(iinst(OP_BEQ, 5, 0, 16'h8), 7, 7, 0, 0, 0, 0, 0);
        cycle(0);
        chk("bh_taken", s_bt, 1);

        // terminate: halted exactly DRAIN cycles after entering drain, sticky
        drive(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
        cycle(0);
        chk("term_stall", s_stall, 1);
        for (int k = 1; k <= 7; k++) begin
            if (k == 5) drive(add324, 0, 0, 0, 0, 0, 0, 0);
            cycle(0);
            chk($sformatf("drain_halted_k%0d", k), b1.halted, k >= DRAIN);
            chk($sformatf("drain_stall_k%0d", k), s_stall, 1);
        end

        // reset two cycles into drain
        cycle(1);
        drive(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
        cycle(0);
        cycle(0);
        cycle(0);
        drive(add324, 0, 0, 0, 0, 0, 0, 0);
        cycle(1);
        cycle(0);
        chk("rd_halted", b1.halted, 0);
        chk("rd_stall", s_stall, 0);
        chk("rd_cnt", b1.stall_cnt, 0);
        chk("rd_alu", b1.alu_op, A_ADD);

        // saturation of the narrow counter
        cycle(1);
        drive(add324, 0, 0, 1, 0, 4, 0, 0);
        for (int k = 0; k < 10; k++) cycle(0);
        chk("sat_w3", b2.stall_cnt, 7);
        chk("sat_w16", b1.stall_cnt, 10);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int sel;
            logic [31:0] ins;
            sel = $urandom_range(0, 99);
            if (sel < 45) begin
                ins = rinst(rnd_fns[$urandom_range(0, 18)], $urandom_range(0, 7),
                            $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31));
            end else if (sel < 92) begin
                ins = iinst(rnd_ops[$urandom_range(1, 11)], $urandom_range(0, 7),
                            $urandom_range(0, 7), 16'($urandom));
            end else if (sel < 95) begin
                ins = 32'hFFFF_FFFF;
            end else begin
                ins = $urandom;
            end
            drive(ins, $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 7));
            cycle($urandom_range(0, 39) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
